// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with stall (freeze), bubble insertion (flush) and
// the architectural status register that latches ALU flags of flag-setting
// instructions as they leave EXE.
module id_exe_reg #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic [WORD_WIDTH-1:0] pc_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic [3:0]            exe_cmd_in,
    input  logic [WORD_WIDTH-1:0] val_rn_in,
    input  logic [WORD_WIDTH-1:0] val_rm_in,
    input  logic                  imm_in,
    input  logic [11:0]           shift_operand_in,
    input  logic [23:0]           signed_imm_24_in,
    input  logic [3:0]            dest_in,
    input  logic [3:0]            src1_in,
    input  logic [3:0]            src2_in,
    input  logic [3:0]            alu_sr_in,
    output logic [WORD_WIDTH-1:0] pc_out,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic                  b_out,
    output logic                  s_out,
    output logic [3:0]            exe_cmd_out,
    output logic [WORD_WIDTH-1:0] val_rn_out,
    output logic [WORD_WIDTH-1:0] val_rm_out,
    output logic                  imm_out,
    output logic [11:0]           shift_operand_out,
    output logic [23:0]           signed_imm_24_out,
    output logic [3:0]            dest_out,
    output logic [3:0]            src1_out,
    output logic [3:0]            src2_out,
    output logic [3:0]            sr_out,
    output logic                  cin_out
);

    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic                  wb_en_q, wb_en_d;
    logic                  mem_r_en_q, mem_r_en_d;
    logic                  mem_w_en_q, mem_w_en_d;
    logic                  b_q, b_d;
    logic                  s_q, s_d;
    logic [3:0]            exe_cmd_q, exe_cmd_d;
    logic [WORD_WIDTH-1:0] val_rn_q, val_rn_d;
    logic [WORD_WIDTH-1:0] val_rm_q, val_rm_d;
    logic                  imm_q, imm_d;
    logic [11:0]           shift_operand_q, shift_operand_d;
    logic [23:0]           signed_imm_24_q, signed_imm_24_d;
    logic [3:0]            dest_q, dest_d;
    logic [3:0]            src1_q, src1_d;
    logic [3:0]            src2_q, src2_d;
    logic [3:0]            sr_q, sr_d;

    // Next-state for the pipeline fields: flush loads a bubble, freeze holds.
    always_comb begin
        pc_d            = pc_q;
        wb_en_d         = wb_en_q;
        mem_r_en_d      = mem_r_en_q;
        mem_w_en_d      = mem_w_en_q;
        b_d             = b_q;
        s_d             = s_q;
        exe_cmd_d       = exe_cmd_q;
        val_rn_d        = val_rn_q;
        val_rm_d        = val_rm_q;
        imm_d           = imm_q;
        shift_operand_d = shift_operand_q;
        signed_imm_24_d = signed_imm_24_q;
        dest_d          = dest_q;
        src1_d          = src1_q;
        src2_d          = src2_q;
        if (flush) begin
            pc_d            = '0;
            wb_en_d         = 1'b0;
            mem_r_en_d      = 1'b0;
            mem_w_en_d      = 1'b0;
            b_d             = 1'b0;
            s_d             = 1'b0;
            exe_cmd_d       = '0;
            val_rn_d        = '0;
            val_rm_d        = '0;
            imm_d           = 1'b0;
            shift_operand_d = '0;
            signed_imm_24_d = '0;
            dest_d          = '0;
            src1_d          = '0;
            src2_d          = '0;
        end else if (!freeze) begin
            pc_d            = pc_in;
            wb_en_d         = wb_en_in;
            mem_r_en_d      = mem_r_en_in;
            mem_w_en_d      = mem_w_en_in;
            b_d             = b_in;
            s_d             = s_in;
            exe_cmd_d       = exe_cmd_in;
            val_rn_d        = val_rn_in;
            val_rm_d        = val_rm_in;
            imm_d           = imm_in;
            shift_operand_d = shift_operand_in;
            signed_imm_24_d = signed_imm_24_in;
            dest_d          = dest_in;
            src1_d          = src1_in;
            src2_d          = src2_in;
        end
    end

    // Flags update when the instruction in EXE sets them and is actually
    // leaving EXE; a flush still retires that older instruction.
    always_comb begin
        sr_d = sr_q;
        if (!freeze && s_q) begin
            sr_d = alu_sr_in;
        end
    end

    // State register with synchronous reset overriding flush and freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= '0;
            wb_en_q         <= 1'b0;
            mem_r_en_q      <= 1'b0;
            mem_w_en_q      <= 1'b0;
            b_q             <= 1'b0;
            s_q             <= 1'b0;
            exe_cmd_q       <= '0;
            val_rn_q        <= '0;
            val_rm_q        <= '0;
            imm_q           <= 1'b0;
            shift_operand_q <= '0;
            signed_imm_24_q <= '0;
            dest_q          <= '0;
            src1_q          <= '0;
            src2_q          <= '0;
            sr_q            <= '0;
        end else begin
            pc_q            <= pc_d;
            wb_en_q         <= wb_en_d;
            mem_r_en_q      <= mem_r_en_d;
            mem_w_en_q      <= mem_w_en_d;
            b_q             <= b_d;
            s_q             <= s_d;
            exe_cmd_q       <= exe_cmd_d;
            val_rn_q        <= val_rn_d;
            val_rm_q        <= val_rm_d;
            imm_q           <= imm_d;
            shift_operand_q <= shift_operand_d;
            signed_imm_24_q <= signed_imm_24_d;
            dest_q          <= dest_d;
            src1_q          <= src1_d;
            src2_q          <= src2_d;
            sr_q            <= sr_d;
        end
    end

    // Outputs are the registers themselves; carry-in is the C flag.
    always_comb begin
        pc_out            = pc_q;
        wb_en_out         = wb_en_q;
        mem_r_en_out      = mem_r_en_q;
        mem_w_en_out      = mem_w_en_q;
        b_out             = b_q;
        s_out             = s_q;
        exe_cmd_out       = exe_cmd_q;
        val_rn_out        = val_rn_q;
        val_rm_out        = val_rm_q;
        imm_out           = imm_q;
        shift_operand_out = shift_operand_q;
        signed_imm_24_out = signed_imm_24_q;
        dest_out          = dest_q;
        src1_out          = src1_q;
        src2_out          = src2_q;
        sr_out            = sr_q;
        cin_out           = sr_q[2];
    end

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg: the stimulus process drives one cycle at a
// time and queues the expected post-edge state; a monitor pops and compares.
module tb_id_exe_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } bundle_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    freeze = 1'b0;
    logic    flush = 1'b0;
    logic [3:0] alu_sr_in = '0;
    bundle_t din = '0;
    bundle_t dout;
    logic [3:0] sr_out;
    logic       cin_out;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the outputs should be right now.
    bundle_t    m_out = '0;
    logic [3:0] m_sr = '0;

    bundle_t    exp_b_q[$];
    logic [3:0] exp_sr_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    id_exe_reg #(.WORD_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .flush             (flush),
        .pc_in             (din.pc),
        .wb_en_in          (din.wb_en),
        .mem_r_en_in       (din.mem_r_en),
        .mem_w_en_in       (din.mem_w_en),
        .b_in              (din.b),
        .s_in              (din.s),
        .exe_cmd_in        (din.exe_cmd),
        .val_rn_in         (din.val_rn),
        .val_rm_in         (din.val_rm),
        .imm_in            (din.imm),
        .shift_operand_in  (din.shift_operand),
        .signed_imm_24_in  (din.signed_imm_24),
        .dest_in           (din.dest),
        .src1_in           (din.src1),
        .src2_in           (din.src2),
        .alu_sr_in         (alu_sr_in),
        .pc_out            (dout.pc),
        .wb_en_out         (dout.wb_en),
        .mem_r_en_out      (dout.mem_r_en),
        .mem_w_en_out      (dout.mem_w_en),
        .b_out             (dout.b),
        .s_out             (dout.s),
        .exe_cmd_out       (dout.exe_cmd),
        .val_rn_out        (dout.val_rn),
        .val_rm_out        (dout.val_rm),
        .imm_out           (dout.imm),
        .shift_operand_out (dout.shift_operand),
        .signed_imm_24_out (dout.signed_imm_24),
        .dest_out          (dout.dest),
        .src1_out          (dout.src1),
        .src2_out          (dout.src2),
        .sr_out            (sr_out),
        .cin_out           (cin_out)
    );

    function automatic bundle_t rand_bundle();
        bundle_t r;
        r.pc            = $urandom();
        r.wb_en         = 1'($urandom_range(1));
        r.mem_r_en      = 1'($urandom_range(1));
        r.mem_w_en      = 1'($urandom_range(1));
        r.b             = 1'($urandom_range(1));
        r.s             = 1'($urandom_range(1));
        r.exe_cmd       = 4'($urandom_range(15));
        r.val_rn        = $urandom();
        r.val_rm        = $urandom();
        r.imm           = 1'($urandom_range(1));
        r.shift_operand = 12'($urandom_range(4095));
        r.signed_imm_24 = 24'($urandom_range(24'hFFFFFF));
        r.dest          = 4'($urandom_range(15));
        r.src1          = 4'($urandom_range(15));
        r.src2          = 4'($urandom_range(15));
        return r;
    endfunction

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic step(input logic r, input logic f, input logic z, input bundle_t d,
                        input logic [3:0] alu, input string nm);
        @(negedge clk);
        rst       = r;
        flush     = f;
        freeze    = z;
        din       = d;
        alu_sr_in = alu;
        // Flags come from the instruction currently in EXE (old s_out).
        if (r) m_sr = 4'b0000;
        else if (!z && m_out.s) m_sr = alu;
        if (r || f) m_out = '0;
        else if (!z) m_out = d;
        exp_b_q.push_back(m_out);
        exp_sr_q.push_back(m_sr);
        name_q.push_back(nm);
    endtask

    // Monitor: compare every presented output against the queued expectation.
    initial begin
        bundle_t    eb;
        logic [3:0] es;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_b_q.size() > 0) begin
                eb = exp_b_q.pop_front();
                es = exp_sr_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (dout !== eb) begin
                    errors++;
                    $display("FAIL %s fields: got %h expected %h", nm, dout, eb);
                end
                checks++;
                if (sr_out !== es) begin
                    errors++;
                    $display("FAIL %s sr_out: got %b expected %b", nm, sr_out, es);
                end
                checks++;
                if (cin_out !== es[2]) begin
                    errors++;
                    $display("FAIL %s cin_out: got %b expected %b", nm, cin_out, es[2]);
                end
            end
        end
    end

    initial begin
        bundle_t d;
        bundle_t d2;
        bundle_t zb;
        int      wait_cycles;
        zb = '0;

        step(1, 0, 0, rand_bundle(), 4'hF, "reset");

        // Plain load; s_out was 0 so flags must not move.
        d = '0;
        d.pc = 32'h8; d.exe_cmd = 4'b0010; d.val_rn = 32'd5; d.val_rm = 32'd7; d.wb_en = 1'b1;
        step(0, 0, 0, d, 4'hF, "load");

        // Freeze for three cycles with a new PC presented.
        d2 = d; d2.pc = 32'hC;
        for (int i = 0; i < 3; i++) step(0, 0, 1, d2, 4'hF, "freeze_hold");
        step(0, 0, 0, d2, 4'hF, "freeze_release");

        // Flush wins over freeze.
        d = rand_bundle(); d.wb_en = 1'b1; d.mem_w_en = 1'b1; d.s = 1'b0;
        step(0, 0, 0, d, 4'h0, "flush_setup");
        step(0, 1, 1, d, 4'h0, "flush_freeze");

        // Flag update, blocked by freeze, then blocked by s_out=0.
        d = rand_bundle(); d.s = 1'b1;
        step(0, 0, 0, d, 4'h0, "flag_setup");
        step(0, 0, 0, d, 4'b0100, "flag_update");
        step(0, 0, 1, d, 4'b0011, "flag_freeze");
        d2 = rand_bundle(); d2.s = 1'b0;
        step(0, 0, 0, d2, 4'b1010, "flag_last_set");
        step(0, 0, 0, d2, 4'b1111, "flag_s0");

        // Flush still retires the older flag-setting instruction.
        step(0, 0, 0, d, 4'h0, "flush_upd_setup");
        step(0, 1, 0, d, 4'b1000, "flush_update");
        step(0, 0, 0, zb, 4'b0001, "bubble_no_flags");

        // Reset overrides freeze, then the next edge loads normally.
        d = rand_bundle(); d.s = 1'b1;
        step(0, 0, 0, d, 4'h0, "pre_reset");
        step(1, 0, 1, rand_bundle(), 4'hF, "reset_over_freeze");
        step(0, 0, 0, rand_bundle(), 4'hF, "post_reset_load");

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(99) < 3), 1'($urandom_range(99) < 15),
                 1'($urandom_range(99) < 25), rand_bundle(), 4'($urandom_range(15)), "random");
        end

        wait_cycles = 0;
        while (exp_b_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_b_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_b_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter WORD_WIDTH, default 32, datapath width of PC and operand fields.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 freeze  input  1  hazard/memory stall; hold all registered state.
REQ-005 flush  input  1  taken branch; load a bubble.
REQ-006 pc_in  input  WORD_WIDTH  PC+4 of decoded instruction.
REQ-007 wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  input  1 each  decode control bits.
REQ-008 exe_cmd_in  input  4  ALU command from control unit.
REQ-009 val_rn_in, val_rm_in  input  WORD_WIDTH each  register-file read data.
REQ-010 imm_in  input  1  immediate-operand flag.
REQ-011 shift_operand_in  input  12  shifter operand field.
REQ-012 signed_imm_24_in  input  24  branch offset field.
REQ-013 dest_in, src1_in, src2_in  input  4 each  register addresses.
REQ-014 alu_sr_in  input  4  {Z,C,N,V} flags from the ALU for the instruction currently in EXE.
REQ-015 Registered outputs pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm_24_out, dest_out, src1_out, src2_out, each of the same width as its *_in counterpart.
REQ-016 sr_out  output  4  architectural status register {Z,C,N,V}.
REQ-017 cin_out  output  1  carry into the ALU, equal to sr_out[2] (C); combinational from sr_out.

Function
REQ-018 Pipeline register: exactly one cycle of latency from every *_in to its *_out; no combinational path from *_in to *_out.
REQ-019 Per-edge priority: rst > flush > freeze > normal load.
REQ-020 Normal load (rst=0, flush=0, freeze=0): every *_out takes its *_in value.
REQ-021 Freeze (rst=0, flush=0, freeze=1): every *_out and sr_out hold their current values, for any number of consecutive cycles.
REQ-022 Flush (rst=0, flush=1): wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out load 0; exe_cmd_out, dest_out, src1_out, src2_out, imm_out load 0; pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out load 0. Freeze is ignored in that cycle.
REQ-023 Status register update: on an edge with rst=0, freeze=0 and s_out=1, sr_out loads alu_sr_in; otherwise sr_out holds.
REQ-024 Flush does not block a status update: when flush=1, freeze=0 and s_out=1, sr_out loads alu_sr_in on the same edge on which the bubble is loaded, because the flagged instruction is older than the branch.
REQ-025 A bubble (s_out=0 after flush) never modifies sr_out.
REQ-026 Back-to-back flag-setting instructions: each updates sr_out on the edge that leaves EXE. The second instruction's ALU sees cin_out from the first update.
REQ-027 No arithmetic is performed in this block; fields pass bit-exact with no sign extension.

Reset
REQ-028 On a rising edge with rst=1, all *_out and sr_out load 0, so cin_out=0, regardless of freeze, flush or s_out.
REQ-029 Reset asserted mid-stall or mid-flush overrides both; the first edge after rst deasserts behaves per REQ-019..REQ-023.

Verification
REQ-030 Load: rst=0, pc_in=0x00000008, exe_cmd_in=4'b0010, val_rn_in=5, val_rm_in=7, wb_en_in=1, all else 0 -> after one edge pc_out=0x8, exe_cmd_out=4'b0010, val_rn_out=5, val_rm_out=7, wb_en_out=1; sr_out unchanged.
REQ-031 Freeze: latch the values of REQ-030, then drive freeze=1 for 3 cycles with pc_in=0x0C -> pc_out stays 0x8 throughout; pc_out becomes 0x0C on the first edge after freeze=0.
REQ-032 Flush vs freeze: with wb_en_out=1 and mem_w_en_out=1, drive flush=1 and freeze=1 on the same edge -> all control outputs are 0 and pc_out=0 after the edge.
REQ-033 Flags: s_out=1, alu_sr_in=4'b0100 with freeze=0 -> sr_out=4'b0100 and cin_out=1 next cycle. Repeat with freeze=1 -> sr_out unchanged. Repeat with s_out=0 -> sr_out unchanged.
REQ-034 Flush with update: s_out=1, alu_sr_in=4'b1000, flush=1 -> sr_out=4'b1000 and s_out=0 after the edge. The next cycle with alu_sr_in=4'b0001 -> sr_out stays 4'b1000.
REQ-035 Reset: with non-zero state and freeze=1, assert rst for one edge -> all outputs 0 and cin_out=0. On the next edge, with rst=0 and loaded inputs, the outputs capture the inputs.
